// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit FMAT core.
// Owns PC and IR, runs the instruction and data-memory handshakes, and keeps retire/cycle counters.
module instr_sequencer #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter int         MEM_TIMEOUT = 15,
   parameter int         CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   output logic             instrReq_o,
   output logic [7:0]       instrAddr_o,
   input  logic             instrValid_i,
   input  logic [7:0]       instrData_i,
   output logic [7:0]       instr_o,
   input  logic             halt_i,
   input  logic [1:0]       destination_i,
   input  logic             regfileWriteEnable_i,
   input  logic [7:0]       jumpAddr_i,
   input  logic [7:0]       aluResult_i,
   output logic             dataReq_o,
   input  logic             dataAck_i,
   output logic             regfileWriteStrobe_o,
   output logic [7:0]       pc_o,
   output logic             busy_o,
   output logic             halted_o,
   output logic             fault_o,
   output logic [CNT_W-1:0] instrCount_o,
   output logic [CNT_W-1:0] cycleCount_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALTED, S_FAULT
   } state_t;

   localparam logic [7:0]       TMO_LIM  = 8'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [1:0]       DEST_MEM = 2'd2;

   state_t     state;
   state_t     state_d;
   logic [7:0] tmo;
   logic       mem_expire;
   logic       jump_taken;
   logic       unused_alu;

   // Only bit 0 of the ALU result carries the JUMPIF condition.
   assign unused_alu  = ^aluResult_i[7:1];
   assign mem_expire  = (tmo + 8'd1) == TMO_LIM;
   assign jump_taken  = (instr_o[7:4] == 4'hF) && aluResult_i[0];
   assign instrAddr_o = pc_o;
   assign regfileWriteStrobe_o = (state == S_WRITEBACK) && regfileWriteEnable_i;

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE, S_HALTED, S_FAULT: if (start_i) state_d = S_FETCH;
         S_FETCH:    if (instrValid_i) state_d = S_DECODE;
         S_DECODE:   state_d = S_EXECUTE;
         S_EXECUTE: begin
            if (halt_i)                           state_d = S_HALTED;
            else if (destination_i == DEST_MEM)   state_d = S_MEM;
            else                                  state_d = S_WRITEBACK;
         end
         // An acknowledge on the expiry cycle still wins over the timeout.
         S_MEM: begin
            if (dataAck_i)       state_d = S_WRITEBACK;
            else if (mem_expire) state_d = S_FAULT;
         end
         S_WRITEBACK: state_d = S_FETCH;
         default:     state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state        <= S_IDLE;
         pc_o         <= RESET_PC;
         instr_o      <= 8'h00;
         tmo          <= 8'h00;
         instrCount_o <= '0;
         cycleCount_o <= '0;
         instrReq_o   <= 1'b0;
         dataReq_o    <= 1'b0;
         busy_o       <= 1'b0;
         halted_o     <= 1'b0;
         fault_o      <= 1'b0;
      end else begin
         state      <= state_d;
         instrReq_o <= (state_d == S_FETCH);
         dataReq_o  <= (state_d == S_MEM);
         busy_o     <= (state_d inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK});
         halted_o   <= (state_d == S_HALTED);
         fault_o    <= (state_d == S_FAULT);

         if (busy_o && (cycleCount_o != CNT_MAX))
            cycleCount_o <= cycleCount_o + 1'b1;

         case (state)
            S_IDLE, S_HALTED, S_FAULT: begin
               if (start_i) begin
                  pc_o         <= RESET_PC;
                  instrCount_o <= '0;
                  cycleCount_o <= '0;
               end
            end
            S_FETCH: if (instrValid_i) instr_o <= instrData_i;
            S_EXECUTE: begin
               tmo <= 8'h00;
               if (halt_i && (instrCount_o != CNT_MAX))
                  instrCount_o <= instrCount_o + 1'b1;
            end
            S_MEM: if (!dataAck_i) tmo <= tmo + 8'd1;
            S_WRITEBACK: begin
               if (instrCount_o != CNT_MAX)
                  instrCount_o <= instrCount_o + 1'b1;
               pc_o <= jump_taken ? jumpAddr_i : pc_o + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit FMAT core. It owns the program counter and instruction register, and fetches from instruction memory with a valid handshake. It presents the latched instruction to the combinational instruction decoder and gates the decoder's register-file write into a single-cycle strobe. It also sequences data-memory accesses, resolves JUMPIF outcomes from the ALU result, and stops on HALT or on a memory timeout.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset and on every start.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for dataAck_i before FAULT. Range 1..255.
- CNT_W, 16, width of the retired-instruction and cycle counters.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- start_i  in  1  begin or restart execution from RESET_PC. Honoured only in IDLE, HALTED or FAULT.
- instrReq_o  out  1  instruction fetch request.
- instrAddr_o  out  8  fetch address; equals pc_o.
- instrValid_i  in  1  instrData_i is valid this cycle.
- instrData_i  in  8  fetched instruction.
- instr_o  out  8  instruction register; feeds the decoder's instr_i.
- halt_i  in  1  decoder HALT indication.
- destination_i  in  2  decoder destination: 0 = bypass, 1 = ALU, 2 = data memory.
- regfileWriteEnable_i  in  1  decoder register-file write request.
- jumpAddr_i  in  8  decoder jump target.
- aluResult_i  in  8  ALU result; bit 0 is the JUMPIF condition.
- dataReq_o  out  1  data-memory access request; held until acknowledged.
- dataAck_i  in  1  data-memory access complete.
- regfileWriteStrobe_o  out  1  qualified one-cycle register-file write.
- pc_o  out  8  program counter.
- busy_o  out  1  high in FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- halted_o  out  1  high in HALTED.
- fault_o  out  1  high in FAULT.
- instrCount_o  out  CNT_W  retired instructions; saturating.
- cycleCount_o  out  CNT_W  cycles with busy_o high; saturating.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED, FAULT.
- Reset (rst_n_i low at an edge):
  - state = IDLE.
  - pc_o = RESET_PC, instr_o = 8'h00, counters = 0.
  - All strobes, busy_o, halted_o and fault_o = 0.
  - Reset takes priority over any state, including mid-MEM; dataReq_o drops the following cycle.
- IDLE, HALTED, FAULT:
  - start_i moves to FETCH.
  - On that move: pc_o = RESET_PC, both counters cleared, fault_o cleared.
  - start_i has no effect in any other state.
- FETCH:
  - instrReq_o = 1.
  - When instrValid_i = 1: instr_o <= instrData_i, next state DECODE. Otherwise stay in FETCH.
- DECODE: one cycle to let the decoder settle on instr_o. Next state EXECUTE.
- EXECUTE, checked in priority order:
  - halt_i = 1: go to HALTED. PC unchanged (points at the HALT instruction). instrCount increments.
  - destination_i = 2: go to MEM. Timeout counter cleared.
  - otherwise: go to WRITEBACK.
- MEM:
  - dataReq_o = 1.
  - dataAck_i = 1: go to WRITEBACK.
  - Otherwise the timeout counter increments. When it reaches MEM_TIMEOUT without an acknowledge, go to FAULT. No writeback and no PC change occur.
  - dataAck_i arriving in the same cycle the timeout is reached counts as success.
- WRITEBACK, lasting one cycle:
  - regfileWriteStrobe_o = regfileWriteEnable_i.
  - instrCount increments.
  - Next PC: if instr_o[7:4] = 4'hF and aluResult_i[0] = 1, pc = jumpAddr_i. Otherwise pc = pc + 1, modulo 256 (8'hFF wraps to 8'h00).
  - Next state FETCH.
- Counters:
  - cycleCount_o increments on every cycle that busy_o is high.
  - Both counters saturate at all-ones and do not wrap.
- dataAck_i and instrValid_i arriving outside MEM and FETCH respectively are ignored.

## Timing
- Every output is registered except:
  - instrAddr_o, which is a copy of pc_o;
  - regfileWriteStrobe_o, which is the combinational AND of the WRITEBACK state and regfileWriteEnable_i.
- Non-memory instruction with zero-wait fetch: 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK).
- Memory instruction: 5 + W cycles, where W is the number of MEM cycles spent waiting for acknowledge.
- Fetch wait: one extra FETCH cycle per cycle that instrValid_i is low.
- From start_i sampled high to instrReq_o high: 1 cycle.
- HALT: halted_o rises on the edge after EXECUTE. A taken JUMPIF never reaches HALTED in the same instruction.

## Test plan
- Reset, then start_i; instructions 8'h10 (ADD) at PC 0 and 8'h02 (HALT) at PC 1, with instrValid_i always high. Required: one write strobe in cycle 4, halted_o = 1, pc_o = 1, instrCount_o = 2, cycleCount_o = 7.
- JUMPIF 8'hF3 with aluResult_i = 1 and jumpAddr_i = 8'h40. Required: pc_o = 8'h40 after WRITEBACK and no write strobe. Same stimulus with aluResult_i = 0: pc_o increments by 1.
- LOAD 8'h94 with dataAck_i delayed 3 cycles. Required: dataReq_o high for exactly 4 cycles, then one write strobe; instruction takes 8 cycles.
- STORE with dataAck_i held low and MEM_TIMEOUT = 15. Required: fault_o = 1 after 15 MEM cycles, PC unchanged, no strobe. A following start_i clears fault_o and fetches from RESET_PC.
- PC at 8'hFF executing a non-jump instruction. Required: pc_o wraps to 8'h00.
- rst_n_i asserted low mid-MEM. Required: next cycle dataReq_o = 0, state IDLE, counters = 0. start_i asserted while busy is ignored.
